// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Purpose : groups the scan request, mux select/return and result handshake
//           signals of mux_scan_ctrl.
// Signals : start      - request a scan (master -> slave)
//           chan_mask  - channel enable mask, bit i enables mux input A[i]
//           S          - select to the downstream 8-to-1 mux (slave -> master)
//           Y          - mux output returned for sampling (master -> slave)
//           busy       - scanner not idle
//           out_data   - scan result, bit i = sampled Y for channel i
//           out_valid  - result valid
//           out_ready  - consumer accepts result
// Modports: slave  - the scan controller side
//           master - the requester / mux / consumer side
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
    logic       start;
    logic [7:0] chan_mask;
    logic [2:0] S;
    logic       Y;
    logic       busy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  start, chan_mask, Y, out_ready,
        output S, busy, out_data, out_valid
    );

    modport master (
        output start, chan_mask, Y, out_ready,
        input  S, busy, out_data, out_valid
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Purpose : steps the select of an external 8-to-1 mux through every enabled
//           channel, holds each for SETTLE+1 cycles, samples the returned mux
//           output on the last of them and presents the 8-bit result with a
//           valid/ready handshake.
// Ports   : clk    - single clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - mux_scan_ctrl_if.slave (start, chan_mask, S, Y, busy,
//                    out_data, out_valid, out_ready)
// Params  : SETTLE - extra cycles S is held before Y is sampled (0..15)
// Macro   : MUX_SCAN_AUTO_RESTART_EN - when defined, the result handshake
//           restarts a scan with the latched mask instead of returning to idle.
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam bit         HAS_SETTLE = (SETTLE != 0);
    localparam logic [3:0] CNT_LOAD   = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;
    // State entered whenever a new channel is placed on S.
    localparam state_t     ST_AFTER_SEL = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

    state_t     r_state;
    logic [7:0] r_mask;
    logic [3:0] r_cnt;
    logic [2:0] r_s;
    logic       r_busy;
    logic [7:0] r_data;
    logic       r_valid;

    logic [3:0] w_first_in;   // {found, index} of lowest set bit of chan_mask
    logic [3:0] w_next;       // {found, index} of next enabled channel above S
    logic [3:0] w_shift;
`ifdef MUX_SCAN_AUTO_RESTART_EN
    logic [3:0] w_first_lat;  // {found, index} of lowest latched channel
`endif

    // Lowest set bit of m; the downward loop lets the lowest index win.
    function automatic logic [3:0] lowest(input logic [7:0] m);
        logic [3:0] r;
        r = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (m[7 - j]) r = {1'b1, 3'(7 - j)};
        end
        return r;
    endfunction

    always_comb begin
        w_first_in = lowest(bus.chan_mask);
        // S+1 may be 8, which shifts the whole mask out: no higher channel.
        w_shift    = {1'b0, r_s} + 4'd1;
        w_next     = lowest(r_mask & (8'hFF << w_shift));
`ifdef MUX_SCAN_AUTO_RESTART_EN
        w_first_lat = lowest(r_mask);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // An all-zero mask has no first channel, so it is ignored.
                    if (bus.start && w_first_in[3]) begin
                        r_mask  <= bus.chan_mask;
                        r_data  <= '0;
                        r_s     <= w_first_in[2:0];
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= ST_AFTER_SEL;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) r_state <= ST_SAMPLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    r_data[r_s] <= bus.Y;
                    if (w_next[3]) begin
                        r_s     <= w_next[2:0];
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_AFTER_SEL;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
`ifdef MUX_SCAN_AUTO_RESTART_EN
                        r_data  <= '0;
                        r_s     <= w_first_lat[2:0];
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_AFTER_SEL;
`else
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.S         = r_s;
    assign bus.busy      = r_busy;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Purpose : directed self-checking bench for mux_scan_ctrl. Two instances are
//           used: u_dut1 with SETTLE=1 and u_dut0 with SETTLE=0. The mux is
//           modelled by looping a per-instance 8-bit pattern A through S.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [7:0] r_a1;
    logic [7:0] r_a0;

    mux_scan_ctrl_if if1 ();
    mux_scan_ctrl_if if0 ();

    assign if1.Y = r_a1[if1.S];
    assign if0.Y = r_a0[if0.S];

    mux_scan_ctrl #(.SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Full scan on u_dut1 (SETTLE=1): each enabled channel of 'mask' must sit
    // on S for two cycles, in ascending order; mask_mid is applied right after
    // the start edge and must not affect the scan.
    task automatic scan1(input logic [7:0] mask, input logic [7:0] mask_mid,
                         input logic [7:0] a, input logic [7:0] exp_data);
        logic [2:0] ch [8];
        int unsigned k;
        k = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i]) begin
                ch[k] = 3'(i);
                k++;
            end
        end
        r_a1          = a;
        if1.chan_mask = mask;
        if1.start     = 1'b1;
        step();
        if1.start     = 1'b0;
        if1.chan_mask = mask_mid;
        for (int unsigned c = 0; c < 2 * k; c++) begin
            check($sformatf("scan_S_c%0d", c), 32'(if1.S), 32'(ch[c / 2]));
            check($sformatf("scan_valid_c%0d", c), 32'(if1.out_valid), 32'd0);
            step();
        end
        check("scan_valid_end", 32'(if1.out_valid), 32'd1);
        check("scan_data_end", 32'(if1.out_data), 32'(exp_data));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        r_a1          = '0;
        r_a0          = '0;
        if1.start     = 1'b0;
        if1.chan_mask = '0;
        if1.out_ready = 1'b0;
        if0.start     = 1'b0;
        if0.chan_mask = '0;
        if0.out_ready = 1'b0;
        #2;
        check("rst_async_S", 32'(if1.S), 32'd0);
        check("rst_async_busy", 32'(if1.busy), 32'd0);
        do_reset();

        // Reset state
        check("rst_S", 32'(if1.S), 32'd0);
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_valid", 32'(if1.out_valid), 32'd0);
        check("rst_data", 32'(if1.out_data), 32'd0);

        // Full 8-channel scan, SETTLE=1, consumer always ready
        if1.out_ready = 1'b1;
        scan1(8'hFF, 8'hFF, 8'hA5, 8'hA5);
        step();
        check("t1_hs_valid", 32'(if1.out_valid), 32'd0);
`ifdef MUX_SCAN_AUTO_RESTART_EN
        check("t1_hs_busy", 32'(if1.busy), 32'd1);
        check("t1_hs_S", 32'(if1.S), 32'd0);
`else
        check("t1_hs_busy", 32'(if1.busy), 32'd0);
        check("t1_hs_S", 32'(if1.S), 32'd7);
`endif
        if1.out_ready = 1'b0;

        // SETTLE=0, mask 81: S shows only 0 then 7, one cycle each
        do_reset();
        r_a0          = 8'hFF;
        if0.chan_mask = 8'h81;
        if0.start     = 1'b1;
        step();
        if0.start     = 1'b0;
        check("t2_S0", 32'(if0.S), 32'd0);
        check("t2_busy", 32'(if0.busy), 32'd1);
        step();
        check("t2_S7", 32'(if0.S), 32'd7);
        check("t2_valid_early", 32'(if0.out_valid), 32'd0);
        step();
        check("t2_valid", 32'(if0.out_valid), 32'd1);
        check("t2_data", 32'(if0.out_data), 32'h81);

        // Empty mask: start ignored
        do_reset();
        if1.chan_mask = 8'h00;
        if1.start     = 1'b1;
        step();
        if1.start     = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            check($sformatf("t3_busy_c%0d", c), 32'(if1.busy), 32'd0);
            check($sformatf("t3_S_c%0d", c), 32'(if1.S), 32'd0);
            check($sformatf("t3_valid_c%0d", c), 32'(if1.out_valid), 32'd0);
            step();
        end

        // Back-pressure in DONE: result stable, start/mask ignored
        do_reset();
        scan1(8'h36, 8'h36, 8'h5C, 8'h14);
        for (int unsigned c = 0; c < 5; c++) begin
            if1.start     = 1'b1;
            if1.chan_mask = 8'hFF;
            step();
            check($sformatf("t4_hold_valid_c%0d", c), 32'(if1.out_valid), 32'd1);
            check($sformatf("t4_hold_data_c%0d", c), 32'(if1.out_data), 32'h14);
            check($sformatf("t4_hold_S_c%0d", c), 32'(if1.S), 32'd5);
        end
        if1.start     = 1'b0;
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        check("t4_hs_valid", 32'(if1.out_valid), 32'd0);
`ifdef MUX_SCAN_AUTO_RESTART_EN
        check("t4_hs_busy", 32'(if1.busy), 32'd1);
        check("t4_hs_S", 32'(if1.S), 32'd1);
`else
        check("t4_hs_busy", 32'(if1.busy), 32'd0);
        check("t4_hs_S", 32'(if1.S), 32'd5);
        step();
        check("t4_idle_busy", 32'(if1.busy), 32'd0);
`endif

        // Asynchronous reset mid-scan
        do_reset();
        r_a1          = 8'hA5;
        if1.chan_mask = 8'hFF;
        if1.start     = 1'b1;
        step();
        if1.start     = 1'b0;
        step();
        step();
        step();
        check("t5_pre_S", 32'(if1.S), 32'd1);
        check("t5_pre_data", 32'(if1.out_data), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_S", 32'(if1.S), 32'd0);
        check("t5_rst_busy", 32'(if1.busy), 32'd0);
        check("t5_rst_valid", 32'(if1.out_valid), 32'd0);
        check("t5_rst_data", 32'(if1.out_data), 32'd0);
        for (int unsigned c = 0; c < 20; c++) begin
            step();
            check($sformatf("t5_held_valid_c%0d", c), 32'(if1.out_valid), 32'd0);
        end
        rst_n = 1'b1;
        step();
        scan1(8'hFF, 8'hFF, 8'h3C, 8'h3C);

        // Mask change during scan is ignored
        do_reset();
        scan1(8'h0F, 8'hF0, 8'hFF, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
